// File: rtl/p2s_pkg.sv
// Shared types and helpers for the p2s_shift_ctrl parallel-to-serial driver.
package p2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 4;

    // Counter width for a count of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/p2s_bit_timer.sv
// Bit-period timer: divides clk by DIV while run is high and produces the
// serial clock plus a one-cycle end-of-bit strobe.
module p2s_bit_timer
    import p2s_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sclk,
    output logic bit_end
);

    localparam int DW = cnt_width(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(DIV / 2);

    logic [DW-1:0] div_cnt;

    // Held at zero outside SHIFT so every word starts on a fresh bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!run || div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign bit_end = run && (div_cnt == LAST);
    assign sclk    = run && (div_cnt >= HALF);

endmodule

// File: rtl/p2s_shift_ctrl.sv
// Parallel-to-serial shift controller with handshake, generated sclk and latch.
// Optional 16-bit latch-pulse counter on port frame_cnt when P2S_FRAME_CNT_EN is defined.
module p2s_shift_ctrl
    import p2s_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter int   DIV        = DEFAULT_DIV,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             s_in,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             sclk,
    output logic             latch,
    output logic             busy
`ifdef P2S_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
        $error("p2s_shift_ctrl: DIV must be even and >= 2");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("p2s_shift_ctrl: WIDTH must be >= 2");
    end

    state_t          state;
    state_t          next_state;
    logic [BW-1:0]   bit_cnt;
    logic            bit_end;
    logic            accept;
    logic [WIDTH-1:0] q_shifted;

    p2s_bit_timer #(
        .DIV(DIV)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state == SHIFT),
        .sclk   (sclk),
        .bit_end(bit_end)
    );

    assign accept    = in_valid && (state == IDLE);
    assign q_shifted = (MSB_FIRST != 0) ? {q[WIDTH-2:0], s_in} : {s_in, q[WIDTH-1:1]};

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (bit_end && bit_cnt == LAST_BIT) next_state = LATCH;
            LATCH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // bit_cnt clears on the last bit so it never has to hold WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            q       <= in_data;
            bit_cnt <= '0;
        end else if (state == SHIFT && bit_end) begin
            q       <= q_shifted;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign latch    = (state == LATCH);
    assign sout     = (state == SHIFT) ? ((MSB_FIRST != 0) ? q[WIDTH-1] : q[0]) : IDLE_LEVEL;

`ifdef P2S_FRAME_CNT_EN
    logic [15:0] frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (state == LATCH) begin
            frame_q <= frame_q + 16'd1;
        end
    end

    assign frame_cnt = frame_q;
`endif

endmodule
